// File: rtl/act_feed_ctrl.sv
// Sequencer for the per-row activation FIFOs. It loads a tile from the selected
// ping-pong input buffer, drains it with a diagonal skew, then flips the buffer select.
module act_feed_ctrl #(
  parameter int ROW       = 8,
  parameter int LOG_ROW   = 3,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vec,
  input  logic                 src_valid,
  input  logic                 fifo_isempty,
  input  logic                 fifo_isfull,
  output logic                 fifo_write_en,
  output logic [ROW-1:0]       fifo_read_en,
  output logic                 fifo_sel,
  output logic [ROW-1:0]       row_valid,
  output logic                 src_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int                   CMP_W    = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] ROW_N    = CNT_WIDTH'(ROW);
  localparam logic [CNT_WIDTH-1:0] LAST_OFS = CNT_WIDTH'(ROW - 2);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] n_vec, n_vec_nxt;
  logic [CNT_WIDTH-1:0] wcnt, wcnt_nxt;
  logic [CNT_WIDTH-1:0] t, t_nxt;
  logic                 sel_nxt, err_nxt;
  logic [ROW-1:0]       read_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      n_vec     <= '0;
      wcnt      <= '0;
      t         <= '0;
      fifo_sel  <= 1'b0;
      err       <= 1'b0;
      row_valid <= '0;
    end else begin
      state     <= state_nxt;
      n_vec     <= n_vec_nxt;
      wcnt      <= wcnt_nxt;
      t         <= t_nxt;
      fifo_sel  <= sel_nxt;
      err       <= err_nxt;
      // FIFO dout is registered, so data is valid one cycle after its read enable
      row_valid <= read_en;
    end
  end

  always_comb begin
    state_nxt     = state;
    n_vec_nxt     = n_vec;
    wcnt_nxt      = wcnt;
    t_nxt         = t;
    sel_nxt       = fifo_sel;
    err_nxt       = err;
    fifo_write_en = 1'b0;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          // num_vec >= ROW exactly when any bit at or above LOG_ROW is set
          n_vec_nxt = (|num_vec[CNT_WIDTH-1:LOG_ROW]) ? ROW_N : num_vec;
          wcnt_nxt  = '0;
          t_nxt     = '0;
          state_nxt = (num_vec == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        fifo_write_en = src_valid & ~fifo_isfull;
        if (fifo_write_en) begin
          wcnt_nxt = wcnt + ONE;
          if (wcnt + ONE == n_vec) begin
            state_nxt = DRAIN;
            t_nxt     = '0;
          end
        end
      end
      DRAIN: begin
        if (t == n_vec + LAST_OFS) begin
          state_nxt = DONE;
        end else begin
          t_nxt = t + ONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        sel_nxt   = ~fifo_sel;
        err_nxt   = err | ~fifo_isempty;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Staircase: row i reads for N consecutive steps beginning at t = i.
  for (genvar i = 0; i < ROW; i++) begin : g_skew
    localparam logic [CMP_W-1:0] IDX = CMP_W'(i);
    assign read_en[i] = (state == DRAIN) && ({1'b0, t} >= IDX) &&
                        ({1'b0, t} < IDX + {1'b0, n_vec});
  end

  assign fifo_read_en = read_en;
  assign src_ack      = fifo_write_en;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_act_feed_ctrl.sv
// Scoreboard bench for act_feed_ctrl: tile timing is predicted from closed-form
// rules into event queues; a negedge monitor pops and compares them.
module tb_act_feed_ctrl;
  localparam int ROW = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       num_vec = '0;
  logic             src_valid = 1'b0;
  logic             fifo_isempty = 1'b1;
  logic             fifo_isfull = 1'b0;
  logic             fifo_write_en;
  logic [ROW-1:0]   fifo_read_en;
  logic             fifo_sel;
  logic [ROW-1:0]   row_valid;
  logic             src_ack;
  logic             busy;
  logic             done;
  logic             err;

  act_feed_ctrl #(.ROW(ROW), .LOG_ROW(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_vec(num_vec),
    .src_valid(src_valid), .fifo_isempty(fifo_isempty), .fifo_isfull(fifo_isfull),
    .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en), .fifo_sel(fifo_sel),
    .row_valid(row_valid), .src_ack(src_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [ROW-1:0] vec; } vec_ev_t;
  typedef struct { int cyc; bit sel; bit err; } st_ev_t;

  int      cyc = 0;
  int      n_chk = 0;
  int      n_fail = 0;
  int      wq[$];
  vec_ev_t rq[$];
  vec_ev_t vq[$];
  st_ev_t  dq[$];
  st_ev_t  iq[$];
  bit      sel_m = 1'b0;
  bit      err_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  // Monitor
  bit             hit;
  logic [ROW-1:0] expv;
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_outputs",
            32'({fifo_write_en, fifo_read_en, fifo_sel, row_valid, src_ack, busy, done, err}), 32'd0);
    end else begin
      hit = (wq.size() > 0) && (wq[0] == cyc);
      if (fifo_write_en || src_ack || hit) begin
        if (hit) void'(wq.pop_front());
        check("write_en_ack", 32'({fifo_write_en, src_ack}), hit ? 32'd3 : 32'd0);
      end
      hit = (rq.size() > 0) && (rq[0].cyc == cyc);
      if (fifo_read_en != '0 || hit) begin
        expv = hit ? rq[0].vec : '0;
        if (hit) void'(rq.pop_front());
        check("read_en", 32'(fifo_read_en), 32'(expv));
      end
      hit = (vq.size() > 0) && (vq[0].cyc == cyc);
      if (row_valid != '0 || hit) begin
        expv = hit ? vq[0].vec : '0;
        if (hit) void'(vq.pop_front());
        check("row_valid", 32'(row_valid), 32'(expv));
      end
      hit = (dq.size() > 0) && (dq[0].cyc == cyc);
      if (done || hit) begin
        if (hit) begin
          check("done_state", 32'({done, busy, fifo_sel, err}), 32'({1'b1, 1'b1, dq[0].sel, dq[0].err}));
          void'(dq.pop_front());
        end else begin
          check("unexpected_done", 32'(done), 32'd0);
        end
      end
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        check("idle_state", 32'({busy, done, fifo_sel, err}), 32'({1'b0, 1'b0, iq[0].sel, iq[0].err}));
        void'(iq.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    start = 1'b0;
    fifo_isempty = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Runs one tile starting in the current cycle. mode 0: source always valid,
  // 1: source gap in tile cycles 2-3, 2: random source/full pattern.
  task automatic tile(input logic [3:0] nv, input int mode, input bit bad_empty,
                      input bit hold_start, input int abort_t);
    bit             sv[128];
    bit             fl[128];
    logic [ROW-1:0] rv[128];
    int s, n, w, d, cnt;
    s = cyc;
    n = (nv > 4'd8) ? 8 : int'(nv);
    for (int k = 0; k < 128; k++) begin
      if (mode == 2) begin
        sv[k] = ($urandom_range(0, 9) < 7);
        fl[k] = ($urandom_range(0, 9) < 2);
      end else begin
        sv[k] = 1'b1;
        fl[k] = 1'b0;
      end
      if (k >= 40) begin sv[k] = 1'b1; fl[k] = 1'b0; end
      rv[k] = '0;
    end
    if (mode == 1) begin sv[2] = 1'b0; sv[3] = 1'b0; end
    w = s;
    cnt = 0;
    for (int k = 1; k < 128 && cnt < n; k++) begin
      if (sv[k] && !fl[k]) begin
        wq.push_back(s + k);
        cnt++;
        w = s + k;
      end
    end
    if (n == 0) begin
      d = s + 1;
    end else begin
      for (int i = 0; i < ROW; i++)
        for (int r = w + 1 + i; r <= w + n + i; r++) rv[r - s][i] = 1'b1;
      for (int r = w + 1; r <= w + n + ROW - 1; r++) begin
        rq.push_back('{r, rv[r - s]});
        vq.push_back('{r + 1, rv[r - s]});
      end
      d = w + n + ROW;
    end
    dq.push_back('{d, sel_m, err_m});
    err_m = err_m | bad_empty;
    sel_m = ~sel_m;
    iq.push_back('{d + 1, sel_m, err_m});
    for (int p = s; p <= d; p++) begin
      if (p == s) begin
        start = 1'b1;
        num_vec = nv;
      end else begin
        start = hold_start ? 1'b1 : ($urandom_range(0, 3) == 0);
        num_vec = 4'($urandom_range(0, 15));
      end
      src_valid = sv[p - s];
      fifo_isfull = fl[p - s];
      fifo_isempty = (p == d) ? !bad_empty : 1'($urandom_range(0, 1));
      if (abort_t >= 0 && n > 0 && p == w + 1 + abort_t) begin
        rstn = 1'b0;
        start = 1'b0;
        wq.delete(); rq.delete(); vq.delete(); dq.delete(); iq.delete();
        sel_m = 1'b0;
        err_m = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rstn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);
    tile(4'd8, 0, 1'b0, 1'b0, -1);      // nominal
    idle(3);
    tile(4'd4, 1, 1'b0, 1'b0, -1);      // source stall
    idle(2);
    tile(4'd0, 0, 1'b0, 1'b0, -1);      // empty tile
    idle(2);
    tile(4'd12, 0, 1'b0, 1'b0, -1);     // clamped
    idle(2);
    tile(4'd5, 0, 1'b0, 1'b1, -1);      // back-to-back with start held
    tile(4'd3, 0, 1'b0, 1'b1, -1);
    idle(3);
    tile(4'd8, 0, 1'b0, 1'b0, 3);       // reset mid-drain at t=3
    tile(4'd8, 0, 1'b0, 1'b0, -1);
    idle(2);
    tile(4'd6, 2, 1'b1, 1'b0, -1);      // err set
    for (int j = 0; j < 12; j++) begin
      tile(4'($urandom_range(0, 15)), 2, 1'b0, 1'b0, -1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    rstn = 1'b0;
    sel_m = 1'b0;
    err_m = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(2);
    check("queues_drained", 32'(wq.size() + rq.size() + vq.size() + dq.size() + iq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/act_feed_ctrl.md
# act_feed_ctrl

Sequencer for the activation input-alignment stage (the ROW-wide bank of per-row activation FIFOs with a shared write enable, per-row read enables and a two-way input-buffer select). Each tile is handled in three steps. First, it loads a tile of N activation vectors into the FIFOs from the currently selected input buffer. Second, it drains them with the diagonal (staircase) skew the systolic array needs, so row i starts i cycles after row 0. Third, it toggles the buffer select so the next tile comes from the other ping-pong buffer.

## Interface
Parameters:
- ROW, 8, number of array rows, equal to the FIFO count and the per-FIFO depth
- LOG_ROW, 3, log2(ROW)
- CNT_WIDTH, 4, width of the vector count and drain counter; must hold 2*ROW-1

Ports:
- clk  input  1  single clock, all state on the rising edge
- rstn  input  1  reset, asynchronous and active-low
- start  input  1  tile request; sampled only in IDLE
- num_vec  input  CNT_WIDTH  vectors in this tile (N); latched on an accepted start
- src_valid  input  1  the selected input buffer presents a valid vector this cycle
- fifo_isempty  input  1  AND of the FIFO empty flags
- fifo_isfull  input  1  OR of the FIFO full flags
- fifo_write_en  output  1  shared FIFO write enable
- fifo_read_en  output  ROW  per-row FIFO read enable
- fifo_sel  output  1  input-buffer select (0 = in1, 1 = in2)
- row_valid  output  ROW  FIFO output of row i is valid for the array this cycle
- src_ack  output  1  the vector on the source was consumed this cycle
- busy  output  1  a tile is in progress
- done  output  1  one-cycle pulse at tile end
- err  output  1  sticky: the FIFOs were not empty at the end of a drain

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD on start.
  - Latch N = min(num_vec, ROW).
  - If num_vec == 0, go IDLE -> DONE directly; no writes or reads occur.
- LOAD:
  - fifo_write_en = src_valid & ~fifo_isfull; src_ack equals fifo_write_en.
  - wcnt increments on each write.
  - On the write that makes wcnt == N, go to DRAIN with t = 0.
  - If src_valid is low or the FIFOs are full, stall with no write.
- DRAIN:
  - t runs 0 .. N+ROW-2, one step per cycle, and never stalls.
  - fifo_read_en[i] = (t >= i) & (t < i+N), combinational from the registered state and t.
  - After t == N+ROW-2, go to DONE.
- DONE:
  - done = 1 for one cycle; fifo_sel toggles on the exit edge.
  - If fifo_isempty == 0 in this cycle, set err.
  - Always return to IDLE.
- row_valid is fifo_read_en delayed one cycle, matching the FIFO's registered dout (data is valid the cycle after ren).
- busy = (state != IDLE).
- start while busy is ignored, not queued.
- fifo_read_en and fifo_write_en are zero outside DRAIN and LOAD respectively. The block never reads and writes in the same cycle.

## Timing
- Reset values: state IDLE, all counters 0; fifo_write_en, fifo_read_en, fifo_sel, row_valid, src_ack, busy, done and err all 0.
- A reset mid-tile aborts immediately, with no done pulse. fifo_sel returns to 0. The FIFOs share rstn and are emptied as well.
- Cycle numbering (src_valid held high): start is sampled at edge 0.
  - LOAD occupies cycles 1..N.
  - DRAIN occupies cycles N+1..2N+ROW-1.
  - DONE is at cycle 2N+ROW.
  - busy falls after that cycle; start is next accepted at cycle 2N+ROW+1.
- Row i reads in cycles N+1+i .. 2N+i and is valid one cycle later.
- Stalls in LOAD shift all later cycles by the stall count.
- err is cleared only by reset.

## Test plan
- Nominal tile: ROW=8, num_vec=8, src_valid=1, start at cycle 0.
  - Required: 8 writes in cycles 1-8.
  - fifo_read_en[0] high in cycles 9-16 and fifo_read_en[7] high in cycles 16-23.
  - done at cycle 24, fifo_sel=1 afterwards, err=0.
- Source stall: num_vec=4 with src_valid low in cycles 2-3.
  - Required: writes in cycles 1, 4, 5 and 6; DRAIN starts at cycle 7; done at cycle 18.
- Boundaries:
  - num_vec=0 -> done at cycle 1, no enables asserted, fifo_sel toggles.
  - num_vec=12 -> clamped to 8, same timing as the nominal tile.
- Back-to-back tiles: start held high.
  - Required: the second tile begins LOAD the cycle after IDLE is re-entered.
  - fifo_sel is 0 for tile 1, 1 for tile 2, and 0 afterwards.
  - start pulses during busy have no effect.
- Reset mid-DRAIN (t=3): deassert rstn.
  - Required: all outputs are 0 asynchronously and no done pulse occurs.
  - After release, a fresh start with num_vec=8 gives the nominal timing.
- Error flag: hold fifo_isempty=0 during the DONE cycle.
  - Required: err=1 and stays set through later tiles until reset.
